operand_bypass_unit: RTL and testbench

Parametrised operand-select and forwarding block for the execute stage of the pipelined CPU. It keeps a DEPTH-entry history of recent register-file results, including results still pending from memory. For each operand request it returns either the youngest matching in-flight value, a register-file value, a sign- or zero-extended immediate, or the PC. When the youngest match is not yet available it raises a stall.

---
 rtl/operand_bypass_unit.sv | 131 +++++++++++++
 tb/tb_operand_bypass_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/operand_bypass_unit.sv
// Execute-stage operand select with a DEPTH-entry forwarding history.
// Pending load results are filled in place and raise stall when they are the youngest match.
module operand_bypass_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int RA_W  = 4,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [RA_W-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_ready,
    input  logic             fill_en,
    input  logic [WIDTH-1:0] fill_data,
    input  logic [2:0]       src_mode,
    input  logic [RA_W-1:0]  src_addr,
    input  logic [WIDTH-1:0] rf_data,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] src,
    output logic             hit,
    output logic             stall,
    output logic             err
);

    typedef struct packed {
        logic             valid;
        logic             ready;
        logic [RA_W-1:0]  addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] hist_q, hist_d;
    entry_t [DEPTH-1:0] filled;
    logic               err_q, err_d;
    logic               fill_found;

    logic               m_hit;
    logic               m_ready;
    logic [WIDTH-1:0]   m_data;
    logic [IMM_W/2-1:0] imm_lo;

    // Fill targets the oldest pending entry, then the filled view is what shifts.
    always_comb begin
        filled     = hist_q;
        fill_found = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (fill_en && !fill_found && hist_q[k].valid && !hist_q[k].ready) begin
                filled[k].data  = fill_data;
                filled[k].ready = 1'b1;
                fill_found      = 1'b1;
            end
        end
    end

    always_comb begin
        hist_d = filled;
        err_d  = err_q;
        if (flush) begin
            hist_d = hist_q;
            for (int k = 0; k < DEPTH; k++) begin
                hist_d[k].valid = 1'b0;
            end
        end else if (adv) begin
            if (filled[DEPTH-1].valid && !filled[DEPTH-1].ready) begin
                err_d = 1'b1;
            end
            for (int k = DEPTH - 1; k >= 1; k--) begin
                hist_d[k] = filled[k-1];
            end
            hist_d[0].valid = wr_en && (wr_addr != '0);
            hist_d[0].ready = wr_ready;
            hist_d[0].addr  = wr_addr;
            hist_d[0].data  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            err_q  <= err_d;
        end
    end

    // Youngest match wins: scan oldest to youngest so lower k overwrites.
    always_comb begin
        m_hit   = 1'b0;
        m_ready = 1'b0;
        m_data  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((src_addr != '0) && hist_q[k].valid && (hist_q[k].addr == src_addr)) begin
                m_hit   = 1'b1;
                m_ready = hist_q[k].ready;
                m_data  = hist_q[k].data;
            end
        end
    end

    assign imm_lo = imm[IMM_W/2-1:0];

    always_comb begin
        src   = '0;
        hit   = 1'b0;
        stall = 1'b0;
        case (src_mode)
            3'd1: src = WIDTH'($signed(imm_lo));
            3'd2: src = WIDTH'($signed(imm));
            3'd3: src = pc;
            3'd4: src = WIDTH'(imm);
            default: begin
                if (m_hit) begin
                    src   = m_data;
                    hit   = 1'b1;
                    stall = !m_ready;
                end else if (src_addr != '0) begin
                    src = rf_data;
                end
            end
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit at default parameters (WIDTH=16, DEPTH=3).
module tb_operand_bypass_unit;

    logic        clk = 1'b0;
    logic        rst, adv, flush, wr_en, wr_ready, fill_en;
    logic [3:0]  wr_addr, src_addr;
    logic [15:0] wr_data, fill_data, rf_data, pc;
    logic [2:0]  src_mode;
    logic [7:0]  imm;
    logic [15:0] src;
    logic        hit, stall, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_bypass_unit dut (
        .clk(clk), .rst(rst), .adv(adv), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .fill_en(fill_en), .fill_data(fill_data),
        .src_mode(src_mode), .src_addr(src_addr), .rf_data(rf_data),
        .imm(imm), .pc(pc),
        .src(src), .hit(hit), .stall(stall), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic rdy);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_ready = rdy; adv = 1'b1;
        step();
        wr_en = 1'b0; adv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; adv = 0; flush = 0; wr_en = 0; wr_ready = 0; fill_en = 0;
        wr_addr = 0; src_addr = 0; wr_data = 0; fill_data = 0; rf_data = 0;
        pc = 0; src_mode = 0; imm = 0;
        step(); step();
        rst = 1'b0;

        // reset state
        src_mode = 0; src_addr = 4'd3; rf_data = 16'hDEAD; #1;
        check("rst_src", src, 16'hDEAD);
        check("rst_hit", hit, 0);
        check("rst_stall", stall, 0);
        check("rst_err", err, 0);

        // forwarding priority and fall-off after DEPTH advances
        wr(4'd3, 16'h1111, 1'b1);
        wr(4'd3, 16'h2222, 1'b1);
        src_addr = 4'd3; #1;
        check("fwd_src", src, 16'h2222);
        check("fwd_hit", hit, 1);
        adv = 1'b1; step(); step(); adv = 1'b0; #1;
        check("fwd_age2_src", src, 16'h2222);
        adv = 1'b1; step(); adv = 1'b0; #1;
        check("fwd_age3_src", src, 16'hDEAD);
        check("fwd_age3_hit", hit, 0);

        // load pending then fill
        wr(4'd5, 16'h0000, 1'b0);
        src_addr = 4'd5; #1;
        check("ld_stall", stall, 1);
        check("ld_hit", hit, 1);
        fill_en = 1'b1; fill_data = 16'h00AB; #1;
        check("ld_same_cycle_stall", stall, 1);
        step(); fill_en = 1'b0; #1;
        check("ld_fill_src", src, 16'h00AB);
        check("ld_fill_stall", stall, 0);

        // fill goes to the oldest pending entry
        flush = 1'b1; step(); flush = 1'b0;
        wr(4'd4, 16'h0000, 1'b0);
        wr(4'd6, 16'h0000, 1'b0);
        fill_en = 1'b1; fill_data = 16'h0AAA; step(); fill_en = 1'b0;
        src_addr = 4'd4; #1;
        check("oldest_fill_src", src, 16'h0AAA);
        check("oldest_fill_stall", stall, 0);
        src_addr = 4'd6; #1;
        check("young_still_stall", stall, 1);

        // pending entry ages out
        flush = 1'b1; step(); flush = 1'b0;
        wr(4'd7, 16'h0000, 1'b0);
        adv = 1'b1; step(); step(); adv = 1'b0; #1;
        check("age_err_before", err, 0);
        adv = 1'b1; step(); adv = 1'b0; #1;
        check("age_err_set", err, 1);
        flush = 1'b1; step(); flush = 1'b0; #1;
        check("age_err_flush", err, 1);
        rst = 1'b1; step(); rst = 1'b0; #1;
        check("age_err_rst", err, 0);

        // flush suppresses insert; r0 never forwards
        flush = 1'b1; wr(4'd2, 16'h5555, 1'b1); flush = 1'b0;
        src_addr = 4'd2; rf_data = 16'hBEEF; #1;
        check("flush_src", src, 16'hBEEF);
        check("flush_hit", hit, 0);
        wr(4'd0, 16'h1234, 1'b1);
        src_addr = 4'd0; #1;
        check("r0_src", src, 16'h0000);
        check("r0_hit", hit, 0);

        // immediate modes ignore a pending match
        wr(4'd9, 16'h0042, 1'b0);
        src_addr = 4'd9; imm = 8'h9C; pc = 16'h0040;
        src_mode = 3'd1; #1;
        check("m1_src", src, 16'hFFFC);
        check("m1_stall", stall, 0);
        check("m1_hit", hit, 0);
        src_mode = 3'd2; #1;
        check("m2_src", src, 16'hFF9C);
        src_mode = 3'd3; #1;
        check("m3_src", src, 16'h0040);
        src_mode = 3'd4; #1;
        check("m4_src", src, 16'h009C);
        check("m4_stall", stall, 0);
        src_mode = 3'd5; #1;
        check("m5_stall", stall, 1);
        check("m5_src", src, 16'h0042);

        // hold: adv=0 ignores wr_*
        src_mode = 3'd0;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h7777; wr_ready = 1'b1; adv = 1'b0;
        step(); wr_en = 1'b0; #1;
        check("hold_stall", stall, 1);
        check("hold_src", src, 16'h0042);
        src_addr = 4'd3; rf_data = 16'hCAFE; #1;
        check("hold_other", src, 16'hCAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
